aes_gcm_keyseq: RTL and testbench

AES_GCM_KEYSEQ -- requirements
Module: aes_gcm_keyseq

---
 rtl/aes_gcm_keyseq.sv | 200 ++++++++++++++++++++
 tb/tb_aes_gcm_keyseq.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_gcm_keyseq.sv
// AES-GCM key/sequence controller: streams the NR+1 round keys one per cycle,
// then paces AAD/text blocks and tags each with its phase and byte count.
//
// state | meaning
// IDLE  | waiting for i_start
// KEXP  | emitting round keys idx 0..NR, one per cycle
// RUN   | accepting blocks 0..T-1
// FIN   | one-cycle completion (o_done)
module aes_gcm_keyseq #(
  parameter int KEY_BITS = 128,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_start,
  input  logic [KEY_BITS-1:0] i_cipher_key,
  input  logic [63:0]         i_aad_len,
  input  logic [63:0]         i_pt_len,
  output logic                o_busy,
  output logic                o_rk_valid,
  output logic [3:0]          o_rk_idx,
  output logic [127:0]        o_rk,
  output logic                o_key_ready,
  input  logic                i_blk_valid,
  output logic                o_blk_ready,
  output logic [1:0]          o_phase,
  output logic [CNT_W-1:0]    o_blk_idx,
  output logic [4:0]          o_last_bytes,
  output logic                o_done
);

  localparam int NK = KEY_BITS / 32;
  localparam int NR = NK + 6;
  localparam logic [3:0] NR_L = 4'(NR);

  typedef enum logic [1:0] {IDLE = 2'd0, KEXP, RUN, FIN} state_e;

  state_e            state_q, state_d;
  logic [3:0]        rk_idx_q, rk_idx_d;
  logic [CNT_W-1:0]  blk_q, blk_d;
  logic [31:0]       win_q [NK];
  logic [31:0]       win_d [NK];
  logic [31:0]       win_sh [NK];
  logic [31:0]       win_key [NK];
  logic [31:0]       nw [4];
  logic [CNT_W-1:0]  a_q, t_q;
  logic [3:0]        aad_rem_q, pt_rem_q;
  logic              p_nz_q;

  logic [60:0]       aad_b, pt_b;
  logic [CNT_W-1:0]  a_cnt, p_cnt, t_last;
  logic              is_last, unused_lsbs;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (x^254) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq, inv;
    sq = x; inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input int n);
    case (n)
      1: return 8'h01;  2: return 8'h02;  3: return 8'h04;  4: return 8'h08;
      5: return 8'h10;  6: return 8'h20;  7: return 8'h40;  8: return 8'h80;
      9: return 8'h1b; 10: return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  assign aad_b       = i_aad_len[63:3];
  assign pt_b        = i_pt_len[63:3];
  assign unused_lsbs = ^{i_aad_len[2:0], i_pt_len[2:0]};
  assign a_cnt  = CNT_W'({7'd0, aad_b[60:4]} + {63'd0, |aad_b[3:0]});
  assign p_cnt  = CNT_W'({7'd0, pt_b[60:4]} + {63'd0, |pt_b[3:0]});
  assign t_last = t_q - CNT_W'(1);
  assign is_last = (blk_q == t_last);

  // Next four schedule words; the window always holds words 4*rk_idx .. 4*rk_idx+NK-1.
  always_comb begin
    logic [31:0] prev, tmp;
    int j;
    prev = win_q[NK-1];
    tmp  = '0;
    j    = 0;
    for (int m = 0; m < 4; m++) begin
      j = NK + 4 * int'(rk_idx_q) + m;
      if (j % NK == 0)
        tmp = sub_word({prev[23:0], prev[31:24]}) ^ {rcon(j / NK), 24'h0};
      else if (NK == 8 && j % NK == 4)
        tmp = sub_word(prev);
      else
        tmp = prev;
      nw[m] = win_q[m] ^ tmp;
      prev  = nw[m];
    end
    for (int k = 0; k < NK; k++) begin
      win_sh[k]  = (k + 4 < NK) ? win_q[(k + 4) % NK] : nw[(k + 8 - NK) % 4];
      win_key[k] = i_cipher_key[KEY_BITS-1-32*k -: 32];
    end
  end

  always_comb begin
    state_d  = state_q;
    rk_idx_d = rk_idx_q;
    blk_d    = blk_q;
    win_d    = win_q;
    case (state_q)
      KEXP: begin
        rk_idx_d = rk_idx_q + 4'd1;
        win_d    = win_sh;
        if (rk_idx_q == NR_L) state_d = (t_q == '0) ? FIN : RUN;
      end
      RUN: begin
        if (i_blk_valid) begin
          blk_d = blk_q + CNT_W'(1);
          if (is_last) state_d = FIN;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = state_q;
    endcase
    // A restart overrides everything, including a block accepted this cycle.
    if (i_start) begin
      state_d  = KEXP;
      rk_idx_d = '0;
      blk_d    = '0;
      win_d    = win_key;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rk_idx_q  <= '0;
      blk_q     <= '0;
      for (int k = 0; k < NK; k++) win_q[k] <= '0;
      a_q       <= '0;
      t_q       <= '0;
      aad_rem_q <= '0;
      pt_rem_q  <= '0;
      p_nz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rk_idx_q <= rk_idx_d;
      blk_q    <= blk_d;
      win_q    <= win_d;
      if (i_start) begin
        a_q       <= a_cnt;
        t_q       <= a_cnt + p_cnt;
        aad_rem_q <= aad_b[3:0];
        pt_rem_q  <= pt_b[3:0];
        p_nz_q    <= |pt_b;
      end
    end
  end

  always_comb begin
    o_busy       = (state_q != IDLE);
    o_rk_valid   = (state_q == KEXP);
    o_rk_idx     = o_rk_valid ? rk_idx_q : 4'd0;
    o_rk         = o_rk_valid ? {win_q[0], win_q[1], win_q[2], win_q[3]} : 128'd0;
    o_key_ready  = (state_q == RUN);
    o_blk_ready  = (state_q == RUN);
    o_blk_idx    = blk_q;
    o_done       = (state_q == FIN);
    o_phase      = 2'b00;
    o_last_bytes = 5'd16;
    if (state_q == RUN) begin
      if (is_last)          o_phase = 2'b11;
      else if (blk_q < a_q) o_phase = 2'b10;
      else                  o_phase = 2'b01;
      // Text tail takes precedence; with no text the AAD tail is the last block.
      if (is_last && p_nz_q)
        o_last_bytes = (pt_rem_q == 4'd0) ? 5'd16 : {1'b0, pt_rem_q};
      else if (a_q != '0 && blk_q == a_q - CNT_W'(1))
        o_last_bytes = (aad_rem_q == 4'd0) ? 5'd16 : {1'b0, aad_rem_q};
    end
  end

endmodule

// File: tb/tb_aes_gcm_keyseq.sv
// Scoreboard bench for aes_gcm_keyseq: stimulus pushes expected round keys,
// blocks and completions; negedge monitors pop and compare.
module tb_aes_gcm_keyseq;

  localparam int CNT_W = 32;
  localparam logic [127:0] K128  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] R128_1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] R128_2 = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] R128_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [255:0] K256 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] R256_2 = 128'h9ba354118e6925afa51a8b5f2067fcde;
  localparam logic [127:0] R256_14 = 128'hfe4890d1e6188d0b046df344706c631e;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, start256, blk_valid;
  logic [63:0] aad_len, pt_len;

  logic        a_busy, a_rkv, a_kr, a_br, a_done;
  logic [3:0]  a_rki;
  logic [127:0] a_rk;
  logic [1:0]  a_ph;
  logic [CNT_W-1:0] a_bi;
  logic [4:0]  a_lb;

  logic        b_busy, b_rkv, b_kr, b_br, b_done;
  logic [3:0]  b_rki;
  logic [127:0] b_rk;
  logic [1:0]  b_ph;
  logic [CNT_W-1:0] b_bi;
  logic [4:0]  b_lb;

  aes_gcm_keyseq #(.KEY_BITS(128), .CNT_W(CNT_W)) u128 (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_cipher_key(K128),
    .i_aad_len(aad_len), .i_pt_len(pt_len), .o_busy(a_busy), .o_rk_valid(a_rkv),
    .o_rk_idx(a_rki), .o_rk(a_rk), .o_key_ready(a_kr), .i_blk_valid(blk_valid),
    .o_blk_ready(a_br), .o_phase(a_ph), .o_blk_idx(a_bi), .o_last_bytes(a_lb),
    .o_done(a_done));

  aes_gcm_keyseq #(.KEY_BITS(256), .CNT_W(CNT_W)) u256 (
    .clk(clk), .rst_n(rst_n), .i_start(start256), .i_cipher_key(K256),
    .i_aad_len(aad_len), .i_pt_len(pt_len), .o_busy(b_busy), .o_rk_valid(b_rkv),
    .o_rk_idx(b_rki), .o_rk(b_rk), .o_key_ready(b_kr), .i_blk_valid(blk_valid),
    .o_blk_ready(b_br), .o_phase(b_ph), .o_blk_idx(b_bi), .o_last_bytes(b_lb),
    .o_done(b_done));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  typedef struct { int cyc; logic [3:0] idx; logic [127:0] rk; bit chk; } rk_exp_t;
  typedef struct { int cyc; logic [31:0] idx; logic [1:0] ph; logic [4:0] lb; } blk_exp_t;

  rk_exp_t  rkq128[$];
  rk_exp_t  rkq256[$];
  blk_exp_t blkq[$];
  int       doneq128[$];
  int       doneq256[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    total++;
    bad++;
    $display("FAIL %s: DUT output with nothing expected (cyc %0d)", name, cyc);
  endtask

  always @(negedge clk) begin
    rk_exp_t e; blk_exp_t b; int d;
    if (a_rkv) begin
      if (rkq128.size() == 0) unexpected("rk128");
      else begin
        e = rkq128.pop_front();
        check("rk128_cyc", cyc, e.cyc);
        check("rk128_idx", a_rki, e.idx);
        if (e.chk) check("rk128_val", a_rk, e.rk);
      end
    end
    if (a_br && blk_valid && !start) begin
      if (blkq.size() == 0) unexpected("blk128");
      else begin
        b = blkq.pop_front();
        check("blk_cyc", cyc, b.cyc);
        check("blk_idx", a_bi, b.idx);
        check("blk_phase", a_ph, b.ph);
        check("blk_last_bytes", a_lb, b.lb);
      end
    end
    if (a_done) begin
      if (doneq128.size() == 0) unexpected("done128");
      else begin
        d = doneq128.pop_front();
        check("done128_cyc", cyc, d);
      end
    end
  end

  always @(negedge clk) begin
    rk_exp_t e; int d;
    if (b_rkv) begin
      if (rkq256.size() == 0) unexpected("rk256");
      else begin
        e = rkq256.pop_front();
        check("rk256_cyc", cyc, e.cyc);
        check("rk256_idx", b_rki, e.idx);
        if (e.chk) check("rk256_val", b_rk, e.rk);
      end
    end
    if (b_br && blk_valid) unexpected("blk256");
    if (b_done) begin
      if (doneq256.size() == 0) unexpected("done256");
      else begin
        d = doneq256.pop_front();
        check("done256_cyc", cyc, d);
      end
    end
  end

  task automatic push_rk128(input int t, input int n);
    rk_exp_t e;
    for (int k = 0; k < n; k++) begin
      e.cyc = t + k; e.idx = 4'(k); e.chk = 1'b1;
      case (k)
        0:       e.rk = K128;
        1:       e.rk = R128_1;
        2:       e.rk = R128_2;
        10:      e.rk = R128_10;
        default: begin e.rk = '0; e.chk = 1'b0; end
      endcase
      rkq128.push_back(e);
    end
  endtask

  task automatic push_rk256(input int t);
    rk_exp_t e;
    for (int k = 0; k < 15; k++) begin
      e.cyc = t + k; e.idx = 4'(k); e.chk = 1'b1;
      case (k)
        0:       e.rk = K256[255:128];
        1:       e.rk = K256[127:0];
        2:       e.rk = R256_2;
        14:      e.rk = R256_14;
        default: begin e.rk = '0; e.chk = 1'b0; end
      endcase
      rkq256.push_back(e);
    end
  endtask

  // Blocks arrive back-to-back with blk_valid held high: block j at t+11+j.
  task automatic push_blk(input int t, input int j, input logic [1:0] ph, input logic [4:0] lb);
    blk_exp_t b;
    b.cyc = t + 11 + j; b.idx = 32'(j); b.ph = ph; b.lb = lb;
    blkq.push_back(b);
  endtask

  task automatic pulse(input bit both, output int t);
    @(posedge clk); #1;
    start = 1'b1;
    start256 = both;
    @(posedge clk); #1;
    start = 1'b0;
    start256 = 1'b0;
    t = cyc;
  endtask

  task automatic run(input logic [63:0] aad, input logic [63:0] pt, input bit both, output int t);
    aad_len = aad;
    pt_len  = pt;
    pulse(both, t);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_busy"}, a_busy, 1'b0);
    check({tag, "_rk_valid"}, a_rkv, 1'b0);
    check({tag, "_rk_idx"}, a_rki, 4'd0);
    check({tag, "_rk"}, a_rk, 128'd0);
    check({tag, "_key_ready"}, a_kr, 1'b0);
    check({tag, "_blk_ready"}, a_br, 1'b0);
    check({tag, "_phase"}, a_ph, 2'b00);
    check({tag, "_blk_idx"}, a_bi, 32'd0);
    check({tag, "_last_bytes"}, a_lb, 5'd16);
    check({tag, "_done"}, a_done, 1'b0);
  endtask

  initial begin
    int t, t2;
    rst_n = 1'b1; start = 1'b0; start256 = 1'b0; blk_valid = 1'b1;
    aad_len = '0; pt_len = '0;
    #2 rst_n = 1'b0;
    #1 check_reset("por");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Empty message on both key sizes: keys only, completion right after idx NR.
    run(64'd0, 64'd0, 1'b1, t);
    push_rk128(t, 11); doneq128.push_back(t + 11);
    push_rk256(t);     doneq256.push_back(t + 15);
    repeat (20) @(posedge clk);
    #1 check("idle_busy", a_busy, 1'b0);

    // 32 AAD bytes + 25 text bytes.
    run(64'd256, 64'd200, 1'b0, t);
    push_rk128(t, 11);
    push_blk(t, 0, 2'b10, 5'd16); push_blk(t, 1, 2'b10, 5'd16);
    push_blk(t, 2, 2'b01, 5'd16); push_blk(t, 3, 2'b11, 5'd9);
    doneq128.push_back(t + 15);
    repeat (20) @(posedge clk);

    // AAD only, 12 bytes.
    run(64'd96, 64'd0, 1'b0, t);
    push_rk128(t, 11);
    push_blk(t, 0, 2'b11, 5'd12);
    doneq128.push_back(t + 12);
    repeat (16) @(posedge clk);

    // 20 AAD bytes (length LSBs set, ignored) + exactly one full text block.
    run(64'd165, 64'd128, 1'b0, t);
    push_rk128(t, 11);
    push_blk(t, 0, 2'b10, 5'd16); push_blk(t, 1, 2'b10, 5'd4);
    push_blk(t, 2, 2'b11, 5'd16);
    doneq128.push_back(t + 14);
    repeat (18) @(posedge clk);

    // Text only, 25 bytes.
    run(64'd0, 64'd200, 1'b0, t);
    push_rk128(t, 11);
    push_blk(t, 0, 2'b01, 5'd16); push_blk(t, 1, 2'b11, 5'd9);
    doneq128.push_back(t + 13);
    repeat (17) @(posedge clk);

    // Restart while block 1 is being accepted: that block is dropped, no done.
    run(64'd256, 64'd200, 1'b0, t);
    push_rk128(t, 11);
    push_blk(t, 0, 2'b10, 5'd16);
    repeat (11) @(posedge clk);
    pulse(1'b0, t2);
    check("abort_cyc", t2, t + 13);
    push_rk128(t2, 11);
    push_blk(t2, 0, 2'b10, 5'd16); push_blk(t2, 1, 2'b10, 5'd16);
    push_blk(t2, 2, 2'b01, 5'd16); push_blk(t2, 3, 2'b11, 5'd9);
    doneq128.push_back(t2 + 15);
    repeat (20) @(posedge clk);

    // Reset in the middle of key expansion, then a fresh instance.
    run(64'd0, 64'd128, 1'b0, t);
    push_rk128(t, 3);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check_reset("midrst");
    @(posedge clk);
    #1 rst_n = 1'b1;
    run(64'd0, 64'd128, 1'b0, t);
    push_rk128(t, 11);
    push_blk(t, 0, 2'b11, 5'd16);
    doneq128.push_back(t + 12);
    repeat (18) @(posedge clk);

    #1;
    check("left_rk128", rkq128.size(), 0);
    check("left_rk256", rkq256.size(), 0);
    check("left_blk", blkq.size(), 0);
    check("left_done128", doneq128.size(), 0);
    check("left_done256", doneq256.size(), 0);
    check("end_busy", a_busy, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
